// File: rtl/store_unit.sv
// store_unit: turns an RV32I store request (SB/SH/SW) into one or two
// word-aligned write beats with byte strobes. A store that crosses a word
// boundary is either split into two beats or rejected with st_err, depending
// on ALLOW_MISALIGNED.
//
// Handshakes:
//   Request side: a request is taken on a rising edge where st_valid=1 and
//   st_ready=1. st_ready is high only in IDLE, and the requester holds its
//   request until then. st_done pulses for one cycle per accepted request,
//   and st_err qualifies it.
//   Memory side: mem_req and its beat fields stay constant until a rising edge
//   with mem_ack=1. mem_ack is ignored whenever mem_req=0.
module store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_size,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    // Second-beat payload, captured at acceptance so BEAT1 needs no re-decode.
    logic [31:0] hi_data_q, hi_data_d;
    logic [3:0]  hi_strb_q, hi_strb_d;

    // Request decode, only meaningful while the request is presented in IDLE.
    logic [1:0]  off;
    logic [7:0]  mask8;
    logic        size_ok;
    logic [7:0]  strb8;
    logic [63:0] data64;
    logic [31:0] base;
    logic        crosses;

    // Size decode: byte mask for SB/SH/SW, anything else is illegal.
    always_comb begin
        mask8   = 8'h00;
        size_ok = 1'b1;
        case (st_size)
            3'd0:    mask8 = 8'h01;
            3'd1:    mask8 = 8'h03;
            3'd2:    mask8 = 8'h0F;
            default: size_ok = 1'b0;
        endcase
    end

    assign off     = st_addr[1:0];
    assign strb8   = mask8 << off;
    assign data64  = {32'b0, st_data} << {off, 3'b000};
    assign base    = {st_addr[31:2], 2'b00};
    assign crosses = |strb8[7:4];

    // Next-state and beat-register update.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        hi_data_d = hi_data_q;
        hi_strb_d = hi_strb_q;
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    if (!size_ok || (!ALLOW_MISALIGNED && crosses)) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_BEAT0;
                        err_d     = 1'b0;
                        addr_d    = base;
                        wdata_d   = data64[31:0];
                        wstrb_d   = strb8[3:0];
                        hi_data_d = data64[63:32];
                        hi_strb_d = strb8[7:4];
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    if (|hi_strb_q) begin
                        // Next word; address wraps naturally at 32 bits.
                        state_d = S_BEAT1;
                        addr_d  = addr_q + 32'd4;
                        wdata_d = hi_data_q;
                        wstrb_d = hi_strb_q;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and beat registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            hi_data_q <= 32'd0;
            hi_strb_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            hi_data_q <= hi_data_d;
            hi_strb_q <= hi_strb_d;
        end
    end

    assign st_ready  = (state_q == S_IDLE);
    assign st_done   = (state_q == S_RESP);
    assign st_err    = (state_q == S_RESP) && err_q;
    assign mem_req   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: one instance splitting misaligned stores, one
// rejecting them. A byte-level memory-image model gives the expected beats.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_size;

    logic        st_valid0, st_ready0, st_done0, st_err0, mem_req0, mem_ack0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [3:0]  mem_wstrb0;
    logic [1:0]  dbg_state0;

    logic        st_valid1, st_ready1, st_done1, st_err1, mem_req1, mem_ack1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [3:0]  mem_wstrb1;
    logic [1:0]  dbg_state1;

    int checks = 0;
    int errors = 0;

    // Observed transaction
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    logic [3:0]  obs_strb_q[$];
    int          obs_done_k;
    logic        obs_err;
    int          obs_unstable;

    // Expected transaction (reference model)
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_strb_q[$];
    int          exp_done_k;
    logic        exp_err;

    store_unit #(.ALLOW_MISALIGNED(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid0), .st_ready(st_ready0),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_done(st_done0), .st_err(st_err0),
        .mem_req(mem_req0), .mem_ack(mem_ack0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_wstrb(mem_wstrb0),
        .dbg_state(dbg_state0)
    );

    store_unit #(.ALLOW_MISALIGNED(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid1), .st_ready(st_ready1),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_done(st_done1), .st_err(st_err1),
        .mem_req(mem_req1), .mem_ack(mem_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1),
        .dbg_state(dbg_state1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lay the rs2 bytes into a byte image starting at the
    // store address, enable only the bytes covered by the size, then cut the
    // image into the words it touches.
    task automatic model_store(input bit allow, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int wait_cyc);
        int nb, off, nbeats, p;
        logic [7:0] img[8];
        bit         en[8];
        exp_addr_q.delete(); exp_data_q.delete(); exp_strb_q.delete();
        exp_err = 1'b1;
        exp_done_k = 1;
        if (size > 3'd2) return;
        nb  = 1 << int'(size);
        off = int'(addr[1:0]);
        if (off + nb > 4 && !allow) return;
        for (int i = 0; i < 8; i++) begin
            img[i] = 8'h00;
            en[i]  = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            p = off + j;
            img[p] = data[8*j +: 8];
            if (j < nb) en[p] = 1'b1;
        end
        nbeats = (off + nb > 4) ? 2 : 1;
        for (int b = 0; b < nbeats; b++) begin
            exp_addr_q.push_back({addr[31:2], 2'b00} + 32'(4 * b));
            exp_data_q.push_back({img[4*b+3], img[4*b+2], img[4*b+1], img[4*b]});
            exp_strb_q.push_back({en[4*b+3], en[4*b+2], en[4*b+1], en[4*b]});
        end
        exp_err = 1'b0;
        exp_done_k = 1 + nbeats * (wait_cyc + 1);
    endtask

    // Driver + monitor: issue one store to dut0 (sel=0) or dut1 (sel=1), ack
    // every beat after wait_cyc idle cycles, record beats and the done cycle
    // (counted from the acceptance edge).
    task automatic run_store(input bit sel, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int wait_cyc);
        int bc;
        logic [31:0] ca, cd;
        logic [3:0]  cs;
        logic        creq, cdone, cerr;
        obs_addr_q.delete(); obs_data_q.delete(); obs_strb_q.delete();
        obs_done_k = -1;
        obs_err = 1'b0;
        obs_unstable = 0;
        for (int i = 0; i < 50 && !(sel ? st_ready1 : st_ready0); i++) begin
            @(posedge clk); #1;
        end
        st_size = size;
        st_addr = addr;
        st_data = data;
        if (sel) st_valid1 = 1'b1; else st_valid0 = 1'b1;
        @(posedge clk); #1;
        st_valid0 = 1'b0;
        st_valid1 = 1'b0;
        bc = 0;
        for (int k = 1; k < 80; k++) begin
            creq  = sel ? mem_req1   : mem_req0;
            ca    = sel ? mem_addr1  : mem_addr0;
            cd    = sel ? mem_wdata1 : mem_wdata0;
            cs    = sel ? mem_wstrb1 : mem_wstrb0;
            cdone = sel ? st_done1   : st_done0;
            cerr  = sel ? st_err1    : st_err0;
            if (creq) begin
                if (bc == 0) begin
                    obs_addr_q.push_back(ca);
                    obs_data_q.push_back(cd);
                    obs_strb_q.push_back(cs);
                end else if (ca !== obs_addr_q[$] || cd !== obs_data_q[$] || cs !== obs_strb_q[$]) begin
                    obs_unstable++;
                end
                if (bc == wait_cyc) begin
                    if (sel) mem_ack1 = 1'b1; else mem_ack0 = 1'b1;
                    bc = 0;
                end else begin
                    mem_ack0 = 1'b0; mem_ack1 = 1'b0;
                    bc++;
                end
            end else begin
                mem_ack0 = 1'b0; mem_ack1 = 1'b0;
            end
            if (cdone) begin
                obs_done_k = k;
                obs_err = cerr;
                break;
            end
            @(posedge clk); #1;
        end
        mem_ack0 = 1'b0;
        mem_ack1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st_valid0 = 0; st_valid1 = 0; mem_ack0 = 0; mem_ack1 = 0;
        st_addr = '0; st_data = '0; st_size = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({st_ready0, st_done0, st_err0, mem_req0} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl0 got %b exp 1000", {st_ready0, st_done0, st_err0, mem_req0});
        end
        checks++;
        if ({mem_addr0, mem_wdata0, mem_wstrb0} !== 68'd0) begin
            errors++; $display("FAIL reset_beat0 got %h %h %h exp 0", mem_addr0, mem_wdata0, mem_wstrb0);
        end
        checks++;
        if ({st_ready1, st_done1, st_err1, mem_req1} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl1 got %b exp 1000", {st_ready1, st_done1, st_err1, mem_req1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({st_ready0, mem_req0, st_ready1, mem_req1} !== 4'b1010) begin
            errors++; $display("FAIL reset_release got %b exp 1010", {st_ready0, mem_req0, st_ready1, mem_req1});
        end
    endtask

    typedef struct {
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          nbeats;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic [31:0] a1, d1;
        logic [3:0]  s1;
        int          done_k;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[5];
        tbl[0] = '{3'd2, 32'h100, 32'hDEADBEEF, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0, 2};
        tbl[1] = '{3'd0, 32'h203, 32'h000000A5, 1, 32'h200, 32'hA5000000, 4'h8, 32'h0, 32'h0, 4'h0, 2};
        tbl[2] = '{3'd1, 32'h202, 32'h00001234, 1, 32'h200, 32'h12340000, 4'hC, 32'h0, 32'h0, 4'h0, 2};
        tbl[3] = '{3'd2, 32'h101, 32'h11223344, 2, 32'h100, 32'h22334400, 4'hE, 32'h104, 32'h00000011, 4'h1, 3};
        tbl[4] = '{3'd2, 32'hFFFFFFFE, 32'hCAFEF00D, 2, 32'hFFFFFFFC, 32'hF00D0000, 4'hC, 32'h0, 32'h0000CAFE, 4'h3, 3};
        for (int t = 0; t < 5; t++) begin
            run_store(1'b0, tbl[t].size, tbl[t].addr, tbl[t].data, 0);
            checks++;
            if (obs_done_k != tbl[t].done_k || obs_err !== 1'b0) begin
                errors++; $display("FAIL dir%0d_done got k=%0d err=%b exp k=%0d err=0", t, obs_done_k, obs_err, tbl[t].done_k);
            end
            checks++;
            if (obs_addr_q.size() != tbl[t].nbeats) begin
                errors++; $display("FAIL dir%0d_nbeats got %0d exp %0d", t, obs_addr_q.size(), tbl[t].nbeats);
            end else begin
                checks++;
                if ({obs_addr_q[0], obs_data_q[0], obs_strb_q[0]} !== {tbl[t].a0, tbl[t].d0, tbl[t].s0}) begin
                    errors++; $display("FAIL dir%0d_beat0 got %h %h %h exp %h %h %h", t,
                        obs_addr_q[0], obs_data_q[0], obs_strb_q[0], tbl[t].a0, tbl[t].d0, tbl[t].s0);
                end
                if (tbl[t].nbeats == 2) begin
                    checks++;
                    if ({obs_addr_q[1], obs_data_q[1], obs_strb_q[1]} !== {tbl[t].a1, tbl[t].d1, tbl[t].s1}) begin
                        errors++; $display("FAIL dir%0d_beat1 got %h %h %h exp %h %h %h", t,
                            obs_addr_q[1], obs_data_q[1], obs_strb_q[1], tbl[t].a1, tbl[t].d1, tbl[t].s1);
                    end
                end
            end
        end
    endtask

    task automatic test_errors();
        // illegal size on the splitting instance, misaligned SH / SW on the rejecting one
        logic [2:0]  sz[3];
        logic [31:0] ad[3];
        bit          sl[3];
        sz[0] = 3'd5; ad[0] = 32'h100; sl[0] = 1'b0;
        sz[1] = 3'd1; ad[1] = 32'h3;   sl[1] = 1'b1;
        sz[2] = 3'd2; ad[2] = 32'h101; sl[2] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            run_store(sl[t], sz[t], ad[t], 32'h55AA55AA, 0);
            checks++;
            if (obs_done_k != 1 || obs_err !== 1'b1 || obs_addr_q.size() != 0) begin
                errors++; $display("FAIL err%0d got k=%0d err=%b beats=%0d exp k=1 err=1 beats=0",
                    t, obs_done_k, obs_err, obs_addr_q.size());
            end
        end
        // a non-crossing SB still works when misalignment is rejected
        run_store(1'b1, 3'd0, 32'h203, 32'h000000A5, 0);
        checks++;
        if (obs_done_k != 2 || obs_err !== 1'b0 || obs_addr_q.size() != 1) begin
            errors++; $display("FAIL noerr_sb got k=%0d err=%b beats=%0d exp k=2 err=0 beats=1",
                obs_done_k, obs_err, obs_addr_q.size());
        end else begin
            checks++;
            if ({obs_addr_q[0], obs_data_q[0], obs_strb_q[0]} !== {32'h200, 32'hA5000000, 4'h8}) begin
                errors++; $display("FAIL noerr_sb_beat got %h %h %h exp 200 a5000000 8",
                    obs_addr_q[0], obs_data_q[0], obs_strb_q[0]);
            end
        end
    endtask

    task automatic test_stall();
        run_store(1'b0, 3'd2, 32'h101, 32'h11223344, 5);
        checks++;
        if (obs_unstable != 0) begin
            errors++; $display("FAIL stall_stable got %0d changes exp 0", obs_unstable);
        end
        checks++;
        if (obs_done_k != 13 || obs_addr_q.size() != 2) begin
            errors++; $display("FAIL stall_done got k=%0d beats=%0d exp k=13 beats=2", obs_done_k, obs_addr_q.size());
        end else begin
            checks++;
            if ({obs_addr_q[1], obs_data_q[1], obs_strb_q[1]} !== {32'h104, 32'h00000011, 4'h1}) begin
                errors++; $display("FAIL stall_beat1 got %h %h %h exp 104 00000011 1",
                    obs_addr_q[1], obs_data_q[1], obs_strb_q[1]);
            end
        end
    endtask

    task automatic test_stray_ack();
        int bad;
        bad = 0;
        mem_ack0 = 1'b1;
        mem_ack1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_req0 || st_done0 || !st_ready0 || mem_req1 || st_done1 || !st_ready1) bad++;
        end
        mem_ack0 = 1'b0;
        mem_ack1 = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stray_ack got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        run_store(1'b0, 3'd1, 32'h402, 32'h0000BEEF, 0);
        checks++;
        if (st_ready0 !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_in_resp got %b exp 0", st_ready0);
        end
        @(posedge clk); #1;
        checks++;
        if (st_ready0 !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_after_done got %b exp 1", st_ready0);
        end
        run_store(1'b0, 3'd2, 32'h403, 32'hA1B2C3D4, 0);
        model_store(1'b1, 3'd2, 32'h403, 32'hA1B2C3D4, 0);
        checks++;
        if (obs_done_k != exp_done_k || obs_addr_q.size() != exp_addr_q.size()) begin
            errors++; $display("FAIL b2b_second got k=%0d beats=%0d exp k=%0d beats=%0d",
                obs_done_k, obs_addr_q.size(), exp_done_k, exp_addr_q.size());
        end else begin
            for (int b = 0; b < exp_addr_q.size(); b++) begin
                checks++;
                if ({obs_addr_q[b], obs_data_q[b], obs_strb_q[b]} !== {exp_addr_q[b], exp_data_q[b], exp_strb_q[b]}) begin
                    errors++; $display("FAIL b2b_beat%0d got %h %h %h exp %h %h %h", b,
                        obs_addr_q[b], obs_data_q[b], obs_strb_q[b], exp_addr_q[b], exp_data_q[b], exp_strb_q[b]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        for (int i = 0; i < 20 && !st_ready0; i++) begin
            @(posedge clk); #1;
        end
        st_size = 3'd2; st_addr = 32'h102; st_data = 32'h99887766;
        st_valid0 = 1'b1;
        @(posedge clk); #1;
        st_valid0 = 1'b0;
        mem_ack0 = 1'b1;
        @(posedge clk); #1;
        mem_ack0 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req0 !== 1'b1 || mem_addr0 !== 32'h104) begin
            errors++; $display("FAIL rmid_in_beat1 got req=%b addr=%h exp req=1 addr=104", mem_req0, mem_addr0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req0, st_ready0, mem_addr0, mem_wdata0, mem_wstrb0} !== {2'b01, 68'd0}) begin
            errors++; $display("FAIL rmid_async got req=%b rdy=%b %h %h %h exp req=0 rdy=1 0 0 0",
                mem_req0, st_ready0, mem_addr0, mem_wdata0, mem_wstrb0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (st_done0 || mem_req0 || !st_ready0) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL rmid_quiet got %0d bad cycles exp 0", dones);
        end
        run_store(1'b0, 3'd2, 32'h500, 32'h0BADF00D, 0);
        checks++;
        if (obs_done_k != 2 || obs_err !== 1'b0 || obs_addr_q.size() != 1) begin
            errors++; $display("FAIL rmid_next got k=%0d err=%b beats=%0d exp k=2 err=0 beats=1",
                obs_done_k, obs_err, obs_addr_q.size());
        end else begin
            checks++;
            if ({obs_addr_q[0], obs_data_q[0], obs_strb_q[0]} !== {32'h500, 32'h0BADF00D, 4'hF}) begin
                errors++; $display("FAIL rmid_next_beat got %h %h %h exp 500 0badf00d f",
                    obs_addr_q[0], obs_data_q[0], obs_strb_q[0]);
            end
        end
    endtask

    task automatic test_random();
        bit          sel;
        logic [2:0]  size;
        logic [31:0] addr, data;
        int          w;
        for (int n = 0; n < 60; n++) begin
            sel  = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            data = $urandom;
            if (size == 3'd0) data = data & 32'h000000FF;
            if (size == 3'd1) data = data & 32'h0000FFFF;
            w = $urandom_range(0, 3);
            run_store(sel, size, addr, data, w);
            model_store(!sel, size, addr, data, w);
            checks++;
            if (obs_done_k != exp_done_k || obs_err !== exp_err) begin
                errors++; $display("FAIL rnd%0d_done sel=%0d sz=%0d a=%h got k=%0d err=%b exp k=%0d err=%b",
                    n, sel, size, addr, obs_done_k, obs_err, exp_done_k, exp_err);
            end
            checks++;
            if (obs_addr_q.size() != exp_addr_q.size() || obs_unstable != 0) begin
                errors++; $display("FAIL rnd%0d_beats got %0d (unstable %0d) exp %0d (unstable 0)",
                    n, obs_addr_q.size(), obs_unstable, exp_addr_q.size());
            end else begin
                for (int b = 0; b < exp_addr_q.size(); b++) begin
                    checks++;
                    if ({obs_addr_q[b], obs_data_q[b], obs_strb_q[b]} !== {exp_addr_q[b], exp_data_q[b], exp_strb_q[b]}) begin
                        errors++; $display("FAIL rnd%0d_beat%0d got %h %h %h exp %h %h %h", n, b,
                            obs_addr_q[b], obs_data_q[b], obs_strb_q[b], exp_addr_q[b], exp_data_q[b], exp_strb_q[b]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_stall();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
